capture_sequencer: RTL and testbench
====================================

// Module: capture_sequencer
// PURPOSE
//  Sequences one pulse capture from the threshold sampler (10-bit data + write strobe) into a
//  2**ADDR_W x 10 sample RAM. Host arms it; it records qualifying samples at consecutive
//  addresses, closes the window on a quiet gap, full buffer, timeout or abort, then holds
//  done/length/status until the host acknowledges. Sits between the sampler and capture RAM.
// PARAMETERS
//  ADDR_W      10      RAM address width; buffer depth DEPTH = 2**ADDR_W samples
//  GAP_CYCLES  16      consecutive cycles without smp_we that end a capture (>=1)
//  TIMEOUT     65535   max ARMED cycles waiting for first sample; 0 = wait forever (<=65535)
// PORTS
//  clk          in   1         system clock, all logic on rising edge
//  rst          in   1         synchronous active-high reset
//  arm          in   1         pulse: start waiting for a pulse (accepted in IDLE, or DONE with ack)
//  abort        in   1         pulse: cancel ARMED/CAPTURE, return to IDLE
//  ack          in   1         pulse: host has read results; DONE -> IDLE
//  smp_data     in   10        sampler data output
//  smp_we       in   1         sampler write strobe (sample above threshold)
//  ram_we       out  1         capture RAM write enable
//  ram_addr     out  ADDR_W    capture RAM write address
//  ram_din      out  10        capture RAM write data
//  busy         out  1         state is ARMED or CAPTURE
//  done         out  1         state is DONE
//  length       out  ADDR_W+1  samples written in last capture (0..DEPTH)
//  status       out  2         end cause: 0 gap, 1 full, 2 timeout, 3 abort (valid in DONE/IDLE)
// BEHAVIOUR
//  - Reset: state IDLE; ram_we=0, ram_addr=0, ram_din=0, length=0, status=0, busy=0, done=0,
//    gap and timeout counters 0. Reset mid-capture drops the capture; no further RAM writes.
//  - All outputs registered. RAM write latency: smp_we in cycle N -> ram_we/addr/din in N+1.
//  - States: IDLE, ARMED, CAPTURE, DONE (2-bit encoding). Priority per cycle: rst > abort > rest.
//  - IDLE: arm -> ARMED; length<=0, timer<=0. smp_we ignored. abort/ack ignored.
//  - ARMED: smp_we -> write smp_data at addr 0, length<=1, gap<=0, -> CAPTURE (or DONE status=1 if
//    DEPTH==1). Else timer++; if TIMEOUT!=0 and timer==TIMEOUT-1 -> DONE, status=2, length=0.
//    abort -> IDLE, status=3, no write even if smp_we same cycle.
//  - CAPTURE: smp_we -> write at addr=length[ADDR_W-1:0], length++, gap<=0; if new length==DEPTH
//    -> DONE, status=1. No smp_we -> gap++; when gap reaches GAP_CYCLES -> DONE, status=0.
//    abort -> IDLE, status=3; length keeps samples already written; sample on abort cycle dropped.
//  - DONE: outputs held, smp_we ignored (no writes, buffer never wraps). ack -> IDLE;
//    ack and arm same cycle -> ARMED directly (length<=0, timer<=0). arm alone ignored.
//  - length saturates at DEPTH; ram_addr never exceeds DEPTH-1. Counters sized to never wrap.
//  - ram_we asserted only for accepted samples; exactly one cycle per accepted sample.
// TESTING
//  1 arm, 5 back-to-back smp_we (data 200..204), then idle 16 cyc -> addrs 0..4 get 200..204,
//    done asserts 16 cyc after last write strobe's cycle, length=5, status=0.
//  2 ADDR_W=3, arm, 12 continuous smp_we -> exactly 8 writes (addr 0..7), done, length=8,
//    status=1; samples 9..12 produce no ram_we.
//  3 TIMEOUT=100, arm, no smp_we -> done after 100 ARMED cycles, status=2, length=0, no ram_we.
//  4 arm, 3 samples, abort coincident with 4th smp_we -> IDLE, status=3, length=3, 3 writes only.
//  5 in DONE: arm alone -> stays DONE; ack+arm same cycle -> ARMED, length=0, next capture at
//    addr 0. Gap of 15 idle cycles then smp_we keeps CAPTURE (gap counter resets).
//  6 rst asserted during CAPTURE with smp_we high -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/capture_sequencer.sv
// Purpose: sequences one pulse capture from the threshold sampler into the capture RAM.
// Latency: smp_we_i in cycle N -> ram_we_o/ram_addr_o/ram_din_o in cycle N+1; all outputs registered.
// Backpressure: none; the sampler is never stalled, samples outside ARMED/CAPTURE are dropped.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   arm_i, abort_i, ack_i   host control pulses
//   smp_data_i, smp_we_i    sampler data and write strobe
//   ram_we_o/addr_o/din_o   capture RAM write port
//   busy_o, done_o          ARMED/CAPTURE and DONE indications
//   length_o, status_o      samples written and end cause (0 gap, 1 full, 2 timeout, 3 abort)
module capture_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              ack_i,
  input  logic [9:0]        smp_data_i,
  input  logic              smp_we_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [9:0]        ram_din_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   length_o,
  output logic [1:0]        status_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [ADDR_W:0]  DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_CYCLES);
  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] ST_GAP     = 2'd0;
  localparam logic [1:0] ST_FULL    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ABORT   = 2'd3;

  state_t            state_q, state_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [9:0]        ram_din_q, ram_din_d;
  logic [ADDR_W:0]   length_q, length_d;
  logic [1:0]        status_q, status_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [15:0]       timer_q, timer_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d    = state_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    length_d   = length_q;
    status_d   = status_q;
    gap_d      = gap_q;
    timer_d    = timer_q;

    case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          state_d  = S_ARMED;
          length_d = '0;
          timer_d  = '0;
        end
      end

      S_ARMED: begin
        if (abort_i) begin
          state_d  = S_IDLE;
          status_d = ST_ABORT;
        end else if (smp_we_i) begin
          ram_we_d   = 1'b1;
          ram_addr_d = '0;
          ram_din_d  = smp_data_i;
          length_d   = LEN_ONE;
          gap_d      = '0;
          if (DEPTH == LEN_ONE) begin
            state_d  = S_DONE;
            status_d = ST_FULL;
          end else begin
            state_d  = S_CAPTURE;
          end
        end else if ((TIMEOUT != 0) && (timer_q == TMO_LAST)) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
          length_d = '0;
        end else if (timer_q != 16'hFFFF) begin
          // Saturate so an unbounded wait (TIMEOUT == 0) never wraps.
          timer_d = timer_q + 16'd1;
        end
      end

      S_CAPTURE: begin
        if (abort_i) begin
          // Samples already written stay counted; this cycle's sample is dropped.
          state_d  = S_IDLE;
          status_d = ST_ABORT;
        end else if (smp_we_i) begin
          ram_we_d   = 1'b1;
          ram_addr_d = length_q[ADDR_W-1:0];
          ram_din_d  = smp_data_i;
          length_d   = length_q + LEN_ONE;
          gap_d      = '0;
          if (length_d == DEPTH) begin
            state_d  = S_DONE;
            status_d = ST_FULL;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
          if (gap_d == GAP_END) begin
            state_d  = S_DONE;
            status_d = ST_GAP;
          end
        end
      end

      S_DONE: begin
        if (ack_i) begin
          if (arm_i) begin
            state_d  = S_ARMED;
            length_d = '0;
            timer_d  = '0;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      length_q   <= '0;
      status_q   <= '0;
      gap_q      <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      length_q   <= length_d;
      status_q   <= status_d;
      gap_q      <= gap_d;
      timer_q    <= timer_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;
  assign length_o   = length_q;
  assign status_o   = status_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Purpose: directed self-checking bench for capture_sequencer (depth 8, gap 16, timeout 100).
// Latency: inputs driven #1 after a rising edge, outputs checked #1 after the next rising edge.
// Backpressure: none; RAM writes are logged on the falling edge into a shadow memory.
module tb_capture_sequencer;

  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst, arm, abort, ack, smp_we;
  logic [9:0]        smp_data;
  logic              ram_we, busy, done;
  logic [ADDR_W-1:0] ram_addr;
  logic [9:0]        ram_din;
  logic [ADDR_W:0]   length;
  logic [1:0]        status;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  logic [9:0] mem [8];

  capture_sequencer #(.ADDR_W(ADDR_W), .GAP_CYCLES(16), .TIMEOUT(100)) dut (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .abort_i(abort), .ack_i(ack),
    .smp_data_i(smp_data), .smp_we_i(smp_we),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_din_o(ram_din),
    .busy_o(busy), .done_o(done), .length_o(length), .status_o(status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_we) begin
      wr_cnt = wr_cnt + 1;
      mem[ram_addr] = ram_din;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm = 0; abort = 0; ack = 0; smp_we = 0; smp_data = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    step(); step();
    rst = 0;
    tests++; if (ram_we !== 1'b0)  begin fails++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    tests++; if (ram_addr !== 3'd0) begin fails++; $display("FAIL reset_ram_addr got=%0d exp=0", ram_addr); end
    tests++; if (ram_din !== 10'd0) begin fails++; $display("FAIL reset_ram_din got=%0d exp=0", ram_din); end
    tests++; if (length !== 4'd0)   begin fails++; $display("FAIL reset_length got=%0d exp=0", length); end
    tests++; if (status !== 2'd0)   begin fails++; $display("FAIL reset_status got=%0d exp=0", status); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    // smp_we in IDLE must not write
    smp_we = 1; smp_data = 10'd99; step(); smp_we = 0; step();
    tests++; if (wr_cnt !== 0) begin fails++; $display("FAIL idle_no_write got=%0d exp=0", wr_cnt); end
  endtask

  task automatic test_gap_close();
    int k;
    wr_cnt = 0;
    arm = 1; step(); arm = 0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL gap_armed_busy got=%b exp=1", busy); end
    for (int i = 0; i < 5; i++) begin
      smp_we = 1; smp_data = 10'(200 + i);
      step();
      tests++;
      if (ram_we !== 1'b1 || ram_addr !== 3'(i) || ram_din !== 10'(200 + i)) begin
        fails++;
        $display("FAIL gap_write%0d got we=%b addr=%0d din=%0d exp we=1 addr=%0d din=%0d",
                 i, ram_we, ram_addr, ram_din, i, 200 + i);
      end
    end
    smp_we = 0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin step(); k++; end
    tests++; if (k !== 16)       begin fails++; $display("FAIL gap_done_delay got=%0d exp=16", k); end
    tests++; if (length !== 4'd5) begin fails++; $display("FAIL gap_length got=%0d exp=5", length); end
    tests++; if (status !== 2'd0) begin fails++; $display("FAIL gap_status got=%0d exp=0", status); end
    tests++; if (wr_cnt !== 5)    begin fails++; $display("FAIL gap_wr_cnt got=%0d exp=5", wr_cnt); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (mem[i] !== 10'(200 + i)) begin fails++; $display("FAIL gap_mem%0d got=%0d exp=%0d", i, mem[i], 200 + i); end
    end
    ack = 1; step(); ack = 0;
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL gap_ack got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_full();
    wr_cnt = 0;
    arm = 1; step(); arm = 0;
    for (int i = 0; i < 12; i++) begin
      smp_we = 1; smp_data = 10'(300 + i);
      step();
      if (i == 7) begin
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL full_done_at_8 got=%b exp=1", done); end
      end
      if (i >= 8) begin
        tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL full_extra_we%0d got=%b exp=0", i + 1, ram_we); end
      end
    end
    smp_we = 0; step();
    tests++; if (length !== 4'd8) begin fails++; $display("FAIL full_length got=%0d exp=8", length); end
    tests++; if (status !== 2'd1) begin fails++; $display("FAIL full_status got=%0d exp=1", status); end
    tests++; if (wr_cnt !== 8)    begin fails++; $display("FAIL full_wr_cnt got=%0d exp=8", wr_cnt); end
    tests++; if (mem[0] !== 10'd300 || mem[7] !== 10'd307) begin
      fails++; $display("FAIL full_mem got m0=%0d m7=%0d exp 300 307", mem[0], mem[7]);
    end
    ack = 1; step(); ack = 0;
  endtask

  task automatic test_timeout();
    int k;
    wr_cnt = 0;
    arm = 1; step(); arm = 0;
    k = 0;
    while (done !== 1'b1 && k < 200) begin step(); k++; end
    tests++; if (k !== 100)       begin fails++; $display("FAIL tmo_delay got=%0d exp=100", k); end
    tests++; if (status !== 2'd2) begin fails++; $display("FAIL tmo_status got=%0d exp=2", status); end
    tests++; if (length !== 4'd0) begin fails++; $display("FAIL tmo_length got=%0d exp=0", length); end
    tests++; if (wr_cnt !== 0)    begin fails++; $display("FAIL tmo_wr_cnt got=%0d exp=0", wr_cnt); end
    ack = 1; step(); ack = 0;
  endtask

  task automatic test_abort();
    wr_cnt = 0;
    arm = 1; step(); arm = 0;
    for (int i = 0; i < 3; i++) begin
      smp_we = 1; smp_data = 10'(400 + i); step();
    end
    smp_we = 1; smp_data = 10'd403; abort = 1;
    step();
    smp_we = 0; abort = 0;
    tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL abort_we got=%b exp=0", ram_we); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_state got busy=%b done=%b exp 0 0", busy, done); end
    tests++; if (status !== 2'd3) begin fails++; $display("FAIL abort_status got=%0d exp=3", status); end
    tests++; if (length !== 4'd3) begin fails++; $display("FAIL abort_length got=%0d exp=3", length); end
    step();
    tests++; if (wr_cnt !== 3)    begin fails++; $display("FAIL abort_wr_cnt got=%0d exp=3", wr_cnt); end
  endtask

  task automatic test_back_to_back();
    int k;
    arm = 1; step(); arm = 0;
    for (int i = 0; i < 2; i++) begin
      smp_we = 1; smp_data = 10'(500 + i); step();
    end
    smp_we = 0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin step(); k++; end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_first_done got=%b exp=1", done); end
    arm = 1; step(); arm = 0;
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL b2b_arm_alone got done=%b busy=%b exp 1 0", done, busy); end
    ack = 1; arm = 1; step(); ack = 0; arm = 0;
    tests++; if (busy !== 1'b1 || done !== 1'b0 || length !== 4'd0) begin
      fails++; $display("FAIL b2b_rearm got busy=%b done=%b len=%0d exp 1 0 0", busy, done, length);
    end
    smp_we = 1; smp_data = 10'd600; step(); smp_we = 0;
    tests++; if (ram_we !== 1'b1 || ram_addr !== 3'd0 || ram_din !== 10'd600) begin
      fails++; $display("FAIL b2b_first_addr got we=%b addr=%0d din=%0d exp 1 0 600", ram_we, ram_addr, ram_din);
    end
    for (int i = 0; i < 15; i++) step();
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL b2b_gap15 got busy=%b done=%b exp 1 0", busy, done); end
    smp_we = 1; smp_data = 10'd601; step(); smp_we = 0;
    tests++; if (ram_we !== 1'b1 || ram_addr !== 3'd1 || busy !== 1'b1) begin
      fails++; $display("FAIL b2b_second got we=%b addr=%0d busy=%b exp 1 1 1", ram_we, ram_addr, busy);
    end
    for (int i = 0; i < 15; i++) step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_gap_reset got done=%b exp=0", done); end
    step();
    tests++; if (done !== 1'b1 || length !== 4'd2) begin fails++; $display("FAIL b2b_close got done=%b len=%0d exp 1 2", done, length); end
    ack = 1; step(); ack = 0;
  endtask

  task automatic test_reset_mid();
    wr_cnt = 0;
    arm = 1; step(); arm = 0;
    smp_we = 1; smp_data = 10'd700; step();
    smp_data = 10'd701; rst = 1; step();
    rst = 0; smp_we = 0;
    tests++; if (ram_we !== 1'b0 || ram_addr !== 3'd0 || ram_din !== 10'd0) begin
      fails++; $display("FAIL rstmid_ram got we=%b addr=%0d din=%0d exp 0 0 0", ram_we, ram_addr, ram_din);
    end
    tests++; if (busy !== 1'b0 || done !== 1'b0 || length !== 4'd0 || status !== 2'd0) begin
      fails++; $display("FAIL rstmid_ctl got busy=%b done=%b len=%0d st=%0d exp 0 0 0 0", busy, done, length, status);
    end
    step(); step();
    tests++; if (wr_cnt !== 1) begin fails++; $display("FAIL rstmid_wr_cnt got=%0d exp=1", wr_cnt); end
  endtask

  initial begin
    test_reset();
    test_gap_close();
    test_full();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
